// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - 720p60 raster constants, counter widths and TMDS control codes
package video_timing_pkg;

  // 1280x720 @ 60 Hz raster, 74.25 MHz pixel clock
  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;
  localparam int H_TOTAL_720P  = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
  localparam int V_TOTAL_720P  = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

  // Counter widths cover H_TOTAL <= 2048, V_TOTAL <= 1024, FPS <= 64
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int FC_W     = 6;

  // TMDS control-period symbols, indexed by {c1, c0} = {vs, hs} on the blue channel
  function automatic logic [9:0] tmds_ctrl_code(input logic [1:0] i_ctrl);
    logic [9:0] w_code;
    case (i_ctrl)
      2'b00:   w_code = 10'b1101010100;
      2'b01:   w_code = 10'b0010101011;
      2'b10:   w_code = 10'b0101010100;
      default: w_code = 10'b1010101011;
    endcase
    return w_code;
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// rtl/video_timing_gen_sync_delay_line.sv - WIDTH x DEPTH shift register with synchronous reset
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      // No stages: clock and reset are intentionally not used
      logic w_unused;
      assign w_unused = clk_in ^ rst_in;
      assign o_data   = i_data;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift data one stage per clock; reset clears every stage
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster timing generator with delayed sync/enable
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_720P,
  parameter int H_FP       = H_FP_720P,
  parameter int H_SYNC     = H_SYNC_720P,
  parameter int H_BP       = H_BP_720P,
  parameter int V_ACTIVE   = V_ACTIVE_720P,
  parameter int V_FP       = V_FP_720P,
  parameter int V_SYNC     = V_SYNC_720P,
  parameter int V_BP       = V_BP_720P,
  parameter int FPS        = 60,
  parameter int SYNC_DELAY = 0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_W-1:0]     fc_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(V_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_ACT    = HCOUNT_W'(H_ACTIVE);
  localparam logic [VCOUNT_W-1:0] V_ACT    = VCOUNT_W'(V_ACTIVE);
  localparam logic [HCOUNT_W-1:0] HS_FIRST = HCOUNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_W-1:0] HS_LAST  = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VCOUNT_W-1:0] VS_FIRST = VCOUNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_W-1:0] VS_LAST  = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(FPS - 1);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || FPS < 1 || FPS > 64 ||
        SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_params
      $error("video_timing_gen: unsupported parameter set");
    end
  endgenerate

  logic [HCOUNT_W-1:0] r_h;
  logic [VCOUNT_W-1:0] r_v;
  logic [FC_W-1:0]     r_fc;
  logic                r_hs, r_vs, r_ad, r_nf;
  logic                w_hs, w_vs, w_ad, w_nf;
  logic [2:0]          w_sync_dly;

  // Raster position: one pixel per clock, line wrap advances the line counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Region decodes of the current position
  always_comb begin
    w_ad = (r_h < H_ACT) && (r_v < V_ACT);
    w_hs = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
    w_vs = (r_v >= VS_FIRST) && (r_v <= VS_LAST);
    w_nf = (r_h == H_ACT) && (r_v == V_ACT);
  end

  // Register the decodes; the frame counter steps together with the nf pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_ad <= 1'b0;
      r_nf <= 1'b0;
      r_fc <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_ad <= w_ad;
      r_nf <= w_nf;
      hcount_out <= r_h;
      vcount_out <= r_v;
      if (w_nf) r_fc <= (r_fc == FC_LAST) ? '0 : r_fc + 1'b1;
    end
  end

  // Align sync and enable with the downstream pixel pipeline latency
  sync_delay_line #(
    .WIDTH(3),
    .DEPTH(SYNC_DELAY)
  ) u_sync_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_data ({r_hs, r_vs, r_ad}),
    .o_data (w_sync_dly)
  );

  assign hs_out = w_sync_dly[2];
  assign vs_out = w_sync_dly[1];
  assign ad_out = w_sync_dly[0];
  assign nf_out = r_nf;
  assign fc_out = r_fc;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - bench for video_timing_gen (720p default and reduced rasters)
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Reduced raster so full frames fit in a short run: 28 x 19 = 532 clocks per frame
  localparam int S_HA = 16, S_HF = 4, S_HS = 3, S_HB = 5;
  localparam int S_VA = 10, S_VF = 2, S_VS = 3, S_VB = 4;
  localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  logic [10:0] d_h, a_h, b_h;
  logic [9:0]  d_v, a_v, b_v;
  logic        d_hs, d_vs, d_ad, d_nf;
  logic        a_hs, a_vs, a_ad, a_nf;
  logic        b_hs, b_vs, b_ad, b_nf;
  logic [5:0]  d_fc, a_fc, b_fc;

  video_timing_gen u_dflt (
    .clk_in(clk), .rst_in(rst), .hcount_out(d_h), .vcount_out(d_v),
    .hs_out(d_hs), .vs_out(d_vs), .ad_out(d_ad), .nf_out(d_nf), .fc_out(d_fc)
  );

  video_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .FPS(60), .SYNC_DELAY(0)
  ) u_s0 (
    .clk_in(clk), .rst_in(rst), .hcount_out(a_h), .vcount_out(a_v),
    .hs_out(a_hs), .vs_out(a_vs), .ad_out(a_ad), .nf_out(a_nf), .fc_out(a_fc)
  );

  video_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .FPS(60), .SYNC_DELAY(2)
  ) u_s2 (
    .clk_in(clk), .rst_in(rst), .hcount_out(b_h), .vcount_out(b_v),
    .hs_out(b_hs), .vs_out(b_vs), .ad_out(b_ad), .nf_out(b_nf), .fc_out(b_fc)
  );

  int n_vec = 0;
  int n_err = 0;
  int k = 0;          // edges since reset release (0 = reset edge)
  int nf_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  // Reference: the outputs at edge kk describe raster position index kk-1;
  // hs/vs/ad describe position kk-1-delay, or 0 when that index precedes release.
  task automatic model(input int cfg, input int kk,
                       output int h, output int v, output int hs, output int vs,
                       output int ad, output int nf, output int fc);
    int ha, hf, hsw, hb, va, vf, vsw, vb, d, ht, vt, ft, p, pd, ph, pv;
    if (cfg == 0) begin
      ha = 1280; hf = 110; hsw = 40; hb = 220; va = 720; vf = 5; vsw = 5; vb = 20; d = 0;
    end else begin
      ha = S_HA; hf = S_HF; hsw = S_HS; hb = S_HB; va = S_VA; vf = S_VF; vsw = S_VS; vb = S_VB;
      d = (cfg == 2) ? 2 : 0;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ft = ht * vt;
    h = 0; v = 0; hs = 0; vs = 0; ad = 0; nf = 0; fc = 0;
    if (kk > 0) begin
      p  = kk - 1;
      h  = p % ht;
      v  = (p / ht) % vt;
      nf = (h == ha && v == va) ? 1 : 0;
      fc = ((p / ft) + (((p % ft) >= va * ht + ha) ? 1 : 0)) % 60;
      pd = p - d;
      if (pd >= 0) begin
        ph = pd % ht;
        pv = (pd / ht) % vt;
        ad = (ph < ha && pv < va) ? 1 : 0;
        hs = (ph >= ha + hf && ph < ha + hf + hsw) ? 1 : 0;
        vs = (pv >= va + vf && pv < va + vf + vsw) ? 1 : 0;
      end
    end
  endtask

  task automatic check_inst(input string name, input int cfg,
                            input logic [10:0] h, input logic [9:0] v,
                            input logic hs, input logic vs, input logic ad,
                            input logic nf, input logic [5:0] fc);
    int eh, ev, ehs, evs, ead, enf, efc;
    model(cfg, k, eh, ev, ehs, evs, ead, enf, efc);
    check({name, ".hcount"}, 32'(h),  eh);
    check({name, ".vcount"}, 32'(v),  ev);
    check({name, ".hs"},     32'(hs), ehs);
    check({name, ".vs"},     32'(vs), evs);
    check({name, ".ad"},     32'(ad), ead);
    check({name, ".nf"},     32'(nf), enf);
    check({name, ".fc"},     32'(fc), efc);
  endtask

  task automatic tick();
    @(posedge clk);
    k = rst ? 0 : k + 1;
    #1;
    if (a_nf === 1'b1) nf_count++;
    check_inst("dflt", 0, d_h, d_v, d_hs, d_vs, d_ad, d_nf, d_fc);
    check_inst("s0",   1, a_h, a_v, a_hs, a_vs, a_ad, a_nf, a_fc);
    check_inst("s2",   2, b_h, b_v, b_hs, b_vs, b_ad, b_nf, b_fc);
  endtask

  initial begin
    // Reset held for three edges: every output 0
    rst = 1'b1;
    repeat (3) tick();

    // Release: first cycle is position (0,0) with ad=1 on the undelayed instances
    rst = 1'b0;
    nf_count = 0;
    tick();
    check("first.dflt.ad", 32'(d_ad), 1);
    check("first.s2.ad",   32'(b_ad), 0);

    // 60 full reduced frames: lines, hsync windows, vsync lines, nf and fc wrap
    repeat (60 * S_FRAME - 1) tick();
    check("nf.count60", nf_count, 60);
    check("fc.wrapped", 32'(a_fc), 0);

    // Randomly placed reset pulses, including mid-frame and mid-line
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 1200)) tick();
      rst = 1'b1;
      repeat ($urandom_range(1, 2)) tick();
      rst = 1'b0;
      tick();
      check("post_rst.s0.h", 32'(a_h), 0);
    end
    repeat (700) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Free-running raster timing generator. Produces the pixel position, hsync, vsync, active-draw, new-frame pulse and frame count for one video frame.
- Sits directly upstream of the three per-channel TMDS encoders.
  - Its ad_out drives their video-enable input.
  - {vs_out, hs_out} drives the blue channel's control input.
- Counters also address the pixel-generation pipeline; a configurable sync delay keeps sync and enable aligned with that pipeline's latency.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- FPS, 60, frame-counter modulus
- SYNC_DELAY, 0, extra register stages applied to hs/vs/ad only (0..15)

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous, active-high reset
- hcount_out  output  11  horizontal position 0..H_TOTAL-1
- vcount_out  output  10  vertical position 0..V_TOTAL-1
- hs_out  output  1  horizontal sync, active high
- vs_out  output  1  vertical sync, active high
- ad_out  output  1  active draw (pixel inside active region)
- nf_out  output  1  one-cycle new-frame pulse
- fc_out  output  6  frame counter 0..FPS-1

Behaviour:
- One clock (clk_in). Reset is synchronous and active-high (rst_in). All state updates on the rising edge of clk_in only.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
- Reset (rst_in high at an edge):
  - internal position resets to (0,0)
  - every output becomes 0, including fc_out, nf_out and all delay-line stages
- Position counter:
  - advances one pixel per clock
  - h wraps H_TOTAL-1 -> 0 and increments v
  - v wraps V_TOTAL-1 -> 0 at h wrap
- All outputs are registered decodes of the position.
  - At the k-th edge after reset release (k = 1, 2, ...), the outputs describe position index k-1.
  - So the first post-reset cycle shows hcount=0, vcount=0, ad=1.
- Decodes (before delay):
  - ad = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (1390..1429), on every line including blanking lines
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (725..729), for the whole line
  - nf = (h == H_ACTIVE) && (v == V_ACTIVE); exactly one cycle per frame
- Frame counter:
  - fc increments in the same registered cycle that nf is asserted (nf and new fc value appear together)
  - wraps FPS-1 -> 0
- SYNC_DELAY:
  - hs/vs/ad pass through SYNC_DELAY further register stages; hcount/vcount/nf/fc are not delayed
  - SYNC_DELAY=0 means no additional stage
  - delay stages reset to 0, so hs/vs/ad stay 0 for SYNC_DELAY cycles after reset release
- Reset mid-frame:
  - takes effect at that edge, with no completion of the current line
  - fc returns to 0
- Width rules:
  - counters sized for the defaults; parameters must satisfy H_TOTAL <= 2048, V_TOTAL <= 1024, FPS <= 64
  - out-of-range parameter values are unsupported (elaboration-time assertion)
- No input handshakes; the block never stalls.

Decomposition:
- Package video_timing_pkg:
  - 720p60 default constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL)
  - counter width localparams (HCOUNT_W=11, VCOUNT_W=10, FC_W=6)
  - the TMDS control-code mapping is shared there as well
- Sub-module sync_delay_line:
  - parameterised WIDTH and DEPTH shift register with synchronous reset
  - DEPTH=0 is a wire-through
  - instantiated with WIDTH=3 for {hs, vs, ad}

Test Plan:
- Reset release, defaults: hold rst_in 3 cycles, then release -> cycle 1 shows hcount=0, vcount=0, ad=1, hs=0, vs=0, fc=0; hcount=1279 still ad=1; hcount=1280 gives ad=0.
- Hsync window, line 0: hs=0 at hcount=1389, hs=1 at 1390..1429, hs=0 at 1430; hcount 1649 -> 0 with vcount 0 -> 1.
- Vertical region: vcount=719 last ad line; vs=1 across the entirety of lines 725..729 (all hcount values); vs=0 on line 730; vcount 749 -> 0 after hcount 1649.
- Frame pulse and counter: nf=1 only at (1280,720), with fc 0->1 in the same cycle. Run 60 frames: fc reaches 59 then returns to 0 on the 60th nf; exactly 60 nf pulses.
- Reset mid-frame: assert rst_in at (500,300) for 1 cycle -> all outputs 0 that cycle, fc=0; next cycle shows (0,0), ad=1.
- SYNC_DELAY=2: hs/vs/ad sequences equal the SYNC_DELAY=0 sequences shifted by exactly 2 cycles; hcount/vcount/nf/fc identical to the undelayed run; hs/vs/ad are 0 for the first 2 post-reset cycles.
